// File: rtl/pll_seq_pkg.sv
// Shared state encoding and widths for the PLL bring-up reset sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RST,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN,
        FAULT
    } seq_state_t;

    localparam int RETRY_W = 4;

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer for an asynchronous status bit, cleared to 0 on reset.
// Latency: 2 clk from input change to sync_out.
// Backpressure: none, free-running sampler.
module pll_lock_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up and ordered downstream reset release; optional PLL_LOCK_STATS_EN adds lock_loss_count.
// Latency: outputs registered, lock changes act 3 clk after pll_locked moves (2 sync + 1 FSM).
// Backpressure: none; restart pulse preempts everything and re-runs the sequence.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES          = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int NUM_STAGES          = 3,
    parameter int STAGE_GAP_CYCLES    = 8,
    parameter int MAX_RETRIES         = 7
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pll_locked,
    input  logic                  restart,
    output logic                  pll_rst,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  ready,
    output logic                  fault,
    output logic [RETRY_W-1:0]    retry_count
`ifdef PLL_LOCK_STATS_EN
    ,
    output logic [15:0]           lock_loss_count
`endif
);

    localparam int RST_W = $clog2(RST_CYCLES + 1);
    localparam int STB_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int TMO_W = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int GAP_W = $clog2(STAGE_GAP_CYCLES + 1);
    localparam int REL_W = $clog2(NUM_STAGES + 1);

    localparam logic [RST_W-1:0]   RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [STB_W-1:0]   STB_LAST  = STB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(STAGE_GAP_CYCLES - 1);
    localparam logic [REL_W-1:0]   REL_LAST  = REL_W'(NUM_STAGES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    seq_state_t            state, state_nxt;
    logic                  locked_s;
    logic                  enter;
    logic                  gap_done;
    logic [RST_W-1:0]      rst_cnt;
    logic [STB_W-1:0]      stb_cnt;
    logic [TMO_W-1:0]      tmo_cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic [REL_W-1:0]      rel_cnt, rel_nxt;
    logic                  pll_rst_nxt, ready_nxt, fault_nxt;
    logic [NUM_STAGES-1:0] stage_nxt;
    logic [RETRY_W-1:0]    retry_nxt;

    pll_lock_sync u_lock_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (pll_locked),
        .sync_out (locked_s)
    );

    assign gap_done = (gap_cnt == GAP_LAST);
    // A restart re-entering RST must also restart its counters.
    assign enter    = restart || (state_nxt != state);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (restart) begin
            state_nxt = RST;
        end else begin
            unique case (state)
                RST:       if (rst_cnt == RST_LAST) state_nxt = WAIT_LOCK;
                WAIT_LOCK: begin
                    if (locked_s)
                        state_nxt = STABLE;
                    else if (tmo_cnt == TMO_LAST)
                        state_nxt = (retry_count == RETRY_MAX) ? FAULT : RST;
                end
                STABLE: begin
                    if (!locked_s)
                        state_nxt = WAIT_LOCK;
                    else if (stb_cnt == STB_LAST)
                        state_nxt = (NUM_STAGES == 1) ? RUN : RELEASE;
                end
                RELEASE: begin
                    if (!locked_s)
                        state_nxt = RST;
                    else if (gap_done && rel_cnt == REL_LAST)
                        state_nxt = RUN;
                end
                RUN:       if (!locked_s) state_nxt = RST;
                FAULT:     state_nxt = FAULT;
                default:   state_nxt = RST;
            endcase
        end
    end

    always_comb begin
        pll_rst_nxt = (state_nxt == RST) || (state_nxt == FAULT);
        fault_nxt   = (state_nxt == FAULT);
        ready_nxt   = (state_nxt == RUN);

        rel_nxt = '0;
        if (state_nxt == RELEASE)
            rel_nxt = (state == RELEASE) ? rel_cnt + REL_W'(gap_done) : REL_W'(1);

        stage_nxt = '0;
        if (state_nxt == RUN) begin
            stage_nxt = '1;
        end else if (state_nxt == RELEASE) begin
            for (int i = 0; i < NUM_STAGES; i++)
                stage_nxt[i] = (i < int'(rel_nxt));
        end

        // Only a WAIT_LOCK timeout leads from WAIT_LOCK back to RST.
        retry_nxt = retry_count;
        if (restart || (state_nxt == RUN && state != RUN))
            retry_nxt = '0;
        else if (state == WAIT_LOCK && state_nxt == RST)
            retry_nxt = retry_count + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_cnt <= '0;
            stb_cnt <= '0;
            tmo_cnt <= '0;
            gap_cnt <= '0;
            rel_cnt <= '0;
        end else begin
            rst_cnt <= (enter || state != RST)       ? '0 : rst_cnt + 1'b1;
            stb_cnt <= (enter || state != STABLE)    ? '0 : stb_cnt + 1'b1;
            tmo_cnt <= (enter || state != WAIT_LOCK) ? '0 : tmo_cnt + 1'b1;
            gap_cnt <= (enter || state != RELEASE || gap_done) ? '0 : gap_cnt + 1'b1;
            rel_cnt <= rel_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pll_rst     <= 1'b1;
            stage_rst_n <= '0;
            ready       <= 1'b0;
            fault       <= 1'b0;
            retry_count <= '0;
        end else begin
            pll_rst     <= pll_rst_nxt;
            stage_rst_n <= stage_nxt;
            ready       <= ready_nxt;
            fault       <= fault_nxt;
            retry_count <= retry_nxt;
        end
    end

`ifdef PLL_LOCK_STATS_EN
    // Survives restart on purpose: it tracks PLL health across bring-ups.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            lock_loss_count <= '0;
        else if (state == RUN && state_nxt == RST && !restart && lock_loss_count != 16'hFFFF)
            lock_loss_count <= lock_loss_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: timestamp-style reference model checked every cycle plus directed literal checks.
module tb_pll_reset_sequencer;

    localparam int RST_C = 4;
    localparam int STB_C = 8;
    localparam int TMO_C = 32;
    localparam int NS    = 3;
    localparam int GAP_C = 2;
    localparam int MAXR  = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          pll_locked = 1'b0;
    logic          restart = 1'b0;
    logic          pll_rst;
    logic [NS-1:0] stage_rst_n;
    logic          ready;
    logic          fault;
    logic [3:0]    retry_count;
`ifdef PLL_LOCK_STATS_EN
    logic [15:0]   lock_loss_count;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .RST_CYCLES          (RST_C),
        .LOCK_STABLE_CYCLES  (STB_C),
        .LOCK_TIMEOUT_CYCLES (TMO_C),
        .NUM_STAGES          (NS),
        .STAGE_GAP_CYCLES    (GAP_C),
        .MAX_RETRIES         (MAXR)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .pll_locked      (pll_locked),
        .restart         (restart),
        .pll_rst         (pll_rst),
        .stage_rst_n     (stage_rst_n),
        .ready           (ready),
        .fault           (fault),
        .retry_count     (retry_count)
`ifdef PLL_LOCK_STATS_EN
        ,
        .lock_loss_count (lock_loss_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: time since attempt start, lock/unlock run lengths and stages released so far.
    bit q1 = 1'b0, q2 = 1'b0;
    int m_t = 0, m_tmo = 0, m_lk = 0, m_gap = 0, m_rel = 0, m_retry = 0, m_llc = 0;
    bit m_fault = 1'b0;

    function automatic void m_new_attempt();
        m_t = 0; m_tmo = 0; m_lk = 0; m_gap = 0; m_rel = 0;
    endfunction

    function automatic void m_step(input bit ls, input bit rs);
        if (rs) begin
            m_new_attempt(); m_retry = 0; m_fault = 1'b0;
        end else if (m_fault) begin
            m_fault = 1'b1;
        end else if (m_rel > 0) begin
            if (!ls) begin
                if (m_rel == NS && m_llc < 65535) m_llc++;
                m_new_attempt();
            end else if (m_rel < NS) begin
                m_gap++;
                if (m_gap == GAP_C) begin
                    m_gap = 0; m_rel++;
                    if (m_rel == NS) m_retry = 0;
                end
            end
        end else if (m_t < RST_C) begin
            m_t++;
        end else if (ls) begin
            m_lk++;
            if (m_lk == STB_C + 1) begin
                m_rel = 1; m_gap = 0;
                if (m_rel == NS) m_retry = 0;
            end
        end else if (m_lk > 0) begin
            m_lk = 0; m_tmo = 0;
        end else begin
            m_tmo++;
            if (m_tmo == TMO_C) begin
                if (m_retry == MAXR) m_fault = 1'b1;
                else begin m_retry++; m_new_attempt(); end
            end
        end
    endfunction

    function automatic logic [NS-1:0] m_stage();
        logic [NS-1:0] v;
        v = '0;
        if (!m_fault)
            for (int i = 0; i < NS; i++) if (i < m_rel) v[i] = 1'b1;
        return v;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q1 = 1'b0; q2 = 1'b0;
            m_new_attempt(); m_retry = 0; m_fault = 1'b0; m_llc = 0;
        end else begin
            bit ls;
            ls = q2; q2 = q1; q1 = pll_locked;
            m_step(ls, restart);
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            check("pll_rst",     pll_rst,     m_fault || (m_rel == 0 && m_t < RST_C));
            check("stage_rst_n", stage_rst_n, m_stage());
            check("ready",       ready,       !m_fault && m_rel == NS);
            check("fault",       fault,       m_fault);
            check("retry_count", retry_count, m_retry);
`ifdef PLL_LOCK_STATS_EN
            check("lock_loss_count", lock_loss_count, m_llc);
`endif
        end
    end

    initial begin
        int n;
        bit ok;
        int prev;
        int steps;
        bit bad;

        repeat (3) @(negedge clk);
        check("rst_pll_rst", pll_rst, 1);
        check("rst_stage", stage_rst_n, 0);
        check("rst_ready", ready, 0);
        check("rst_fault", fault, 0);
        check("rst_retry", retry_count, 0);
`ifdef PLL_LOCK_STATS_EN
        check("rst_llc", lock_loss_count, 0);
`endif

        // 1. Normal bring-up
        reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (pll_rst) n++;
            @(negedge clk);
        end
        check("s1_pll_rst_cycles", n, RST_C);
        pll_locked = 1'b1;
        n = 0; ok = 1'b0;
        while (n < 60 && !ok) begin
            @(negedge clk); n++;
            if (stage_rst_n != 0) ok = 1'b1;
        end
        check("s1_release_seen", ok, 1);
        check("s1_release_delay", n, 11);
        check("s1_stage_001", stage_rst_n, 3'b001);
        repeat (2) @(negedge clk);
        check("s1_stage_011", stage_rst_n, 3'b011);
        check("s1_ready_early", ready, 0);
        repeat (2) @(negedge clk);
        check("s1_stage_111", stage_rst_n, 3'b111);
        check("s1_ready", ready, 1);

        // 4. Lock loss in RUN
        repeat (3) @(negedge clk);
        pll_locked = 1'b0;
        repeat (3) @(negedge clk);
        check("s4_stage_drop", stage_rst_n, 0);
        check("s4_ready_drop", ready, 0);
        check("s4_pll_rst", pll_rst, 1);
        pll_locked = 1'b1;
        n = 0; ok = 1'b0;
        while (n < 100 && !ok) begin
            @(negedge clk); n++;
            if (ready) ok = 1'b1;
        end
        check("s4_resequence", ok, 1);
        check("s4_stage_111", stage_rst_n, 3'b111);
`ifdef PLL_LOCK_STATS_EN
        check("s4_llc", lock_loss_count, 1);
`endif

        // 5b. Restart coinciding with the synchronized lock drop
        repeat (2) @(negedge clk);
        pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("s5b_pll_rst", pll_rst, 1);
        check("s5b_ready", ready, 0);
        check("s5b_stage", stage_rst_n, 0);
        check("s5b_retry", retry_count, 0);
`ifdef PLL_LOCK_STATS_EN
        check("s5b_llc_unchanged", lock_loss_count, 1);
`endif

        // 2. Glitch during STABLE
        repeat (8) @(negedge clk);
        pll_locked = 1'b1;
        n = 0; ok = 1'b0;
        while (n < 60 && !ok) begin
            @(negedge clk); n++;
            pll_locked = (n != 5);
            if (stage_rst_n != 0) ok = 1'b1;
        end
        check("s2_release_seen", ok, 1);
        check("s2_release_delay", n, 17);
        n = 0; ok = 1'b0;
        while (n < 20 && !ok) begin
            @(negedge clk); n++;
            if (ready) ok = 1'b1;
        end
        check("s2_ready", ok, 1);

        // 3. Timeout and fault
        repeat (2) @(negedge clk);
        pll_locked = 1'b0;
        n = 0; ok = 1'b0; prev = 0; steps = 0; bad = 1'b0;
        while (n < 300 && !ok) begin
            @(negedge clk); n++;
            if (retry_count != prev) begin
                if (retry_count != prev + 1) bad = 1'b1;
                steps++;
                prev = retry_count;
            end
            if (fault) ok = 1'b1;
        end
        check("s3_fault_seen", ok, 1);
        check("s3_fault_delay", n, 111);
        check("s3_retry_steps", steps, 2);
        check("s3_retry_monotonic", bad, 0);
        check("s3_retry_final", retry_count, 2);
        check("s3_pll_rst", pll_rst, 1);
        check("s3_stage", stage_rst_n, 0);

        // 5a. Restart out of FAULT
        repeat (3) @(negedge clk);
        check("s5a_fault_held", fault, 1);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("s5a_fault", fault, 0);
        check("s5a_retry", retry_count, 0);
        check("s5a_pll_rst", pll_rst, 1);

        // 6. Asynchronous reset mid-RELEASE
        pll_locked = 1'b1;
        n = 0; ok = 1'b0;
        while (n < 80 && !ok) begin
            @(negedge clk); n++;
            if (stage_rst_n == 3'b011) ok = 1'b1;
        end
        check("s6_reached_011", ok, 1);
        #2 reset_n = 1'b0;
        #1;
        check("s6_async_stage", stage_rst_n, 0);
        check("s6_async_pll_rst", pll_rst, 1);
        check("s6_async_ready", ready, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized lock behaviour with sporadic restarts
        for (int r = 0; r < 40; r++) begin
            int len;
            pll_locked = ($urandom_range(0, 3) != 0);
            len = pll_locked ? int'($urandom_range(5, 70)) : int'($urandom_range(1, 45));
            for (int c = 0; c < len; c++) begin
                restart = ($urandom_range(0, 150) == 0);
                @(negedge clk);
            end
            restart = 1'b0;
        end
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
